// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch (I), load/store (D) and memory-side signals of the
//   memory arbiter.
//   slave  : arbiter view (requests and memory response in; grant-side outputs out)
//   master : environment view (requesters plus memory model)
// Parameters: ADDR_W address width, DATA_W data width (byte mask = DATA_W/8).
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    // fetch requester
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;
    // load/store requester
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_wmask;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;
    // memory port
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask,
               mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask,
               mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the instruction-fetch path (I) and the
//   load/store path (D). Requests are level-held, one transaction is in
//   flight at a time, and a grant lasts until mem_resp or until the granted
//   requester drops its request.
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : mem_arbiter_if.slave (I/D requester signals and memory port)
// Configuration:
//   MEM_ARB_RR_EN defined   -> round-robin on a tie (grant the one that is not last_grant)
//   MEM_ARB_RR_EN undefined -> fixed priority, D wins every tie
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_e;

    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   i_req, d_req, pick_d;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

    // Read data is shared by both requesters; only the resp strobes are gated.
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;

    // Tie break. last_grant is maintained in both builds but only consulted
    // in round-robin mode.
`ifdef MEM_ARB_RR_EN
    assign pick_d = d_req & (~i_req | (last_grant_q == LG_I));
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= LG_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        bus.i_resp    = 1'b0;
        bus.d_resp    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Registered arbitration: strobes appear the cycle after the request.
                // mem_resp seen here is stale or spurious and is ignored.
                if (pick_d) begin
                    state_d      = GRANT_D;
                    last_grant_d = LG_D;
                end else if (i_req) begin
                    state_d      = GRANT_I;
                    last_grant_d = LG_I;
                end
            end
            GRANT_I: begin
                if (!i_req) begin
                    state_d = IDLE;             // abort: strobes already low, no resp
                end else begin
                    bus.mem_read  = 1'b1;
                    bus.mem_addr  = bus.i_addr;
                    bus.mem_wmask = '1;
                    if (bus.mem_resp) begin
                        bus.i_resp = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            GRANT_D: begin
                if (!d_req) begin
                    state_d = IDLE;
                end else begin
                    // write wins when both read and write are held
                    bus.mem_write = bus.d_write;
                    bus.mem_read  = bus.d_read & ~bus.d_write;
                    bus.mem_addr  = bus.d_addr;
                    bus.mem_wdata = bus.d_wdata;
                    bus.mem_wmask = bus.d_write ? bus.d_wmask : '1;
                    if (bus.mem_resp) begin
                        bus.d_resp = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // step to just after the next rising edge; inputs change here
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_read = 0; bus.i_addr = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_wmask = '0;
        bus.mem_rdata = '0; bus.mem_resp = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        cyc(); cyc();
        rst = 0;
    endtask

    function automatic logic [83:0] outs();
        return {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata,
                bus.mem_wmask, bus.i_resp, bus.d_resp, 10'd0};
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (outs() !== 84'd0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", outs());
        end
    endtask

    task automatic test_fetch();
        bus.i_read = 1; bus.i_addr = 32'h100;
        #1; checks++;
        if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL fetch_idle_strobe got=%b want=0", bus.mem_read); end
        cyc(); #1;
        checks++;
        if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wmask} !== {2'b10, 32'h100, 4'hF}) begin
            errors++; $display("FAIL fetch_strobe got=%b%b %h %h want=10 100 f", bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wmask);
        end
        bus.mem_resp = 1; bus.mem_rdata = 32'hDEADBEEF;
        #1; checks++;
        if ({bus.i_resp, bus.d_resp, bus.i_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL fetch_resp got=%b%b %h want=10 deadbeef", bus.i_resp, bus.d_resp, bus.i_rdata);
        end
        cyc(); bus.mem_resp = 0;
        #1; checks++;
        if ({bus.mem_read, bus.i_resp} !== 2'b00) begin
            errors++; $display("FAIL fetch_turnaround got=%b%b want=00", bus.mem_read, bus.i_resp);
        end
        bus.i_read = 0;
        cyc();
    endtask

    task automatic test_store_wait();
        bus.d_write = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678; bus.d_wmask = 4'h3;
        cyc(); #1;
        checks++;
        if ({bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !==
            {2'b10, 32'h200, 32'h12345678, 4'h3}) begin
            errors++; $display("FAIL store_strobe got=%b%b %h %h %h want=10 200 12345678 3",
                bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
        end
        for (int w = 0; w < 3; w++) begin
            cyc(); #1; checks++;
            if ({bus.d_resp, bus.mem_write} !== 2'b01) begin
                errors++; $display("FAIL store_wait%0d got=%b%b want=01", w, bus.d_resp, bus.mem_write);
            end
        end
        bus.mem_resp = 1;
        #1; checks++;
        if (bus.d_resp !== 1'b1) begin errors++; $display("FAIL store_resp got=%b want=1", bus.d_resp); end
        cyc(); bus.mem_resp = 0; bus.d_write = 0;
        #1; checks++;
        if ({bus.d_resp, bus.mem_write} !== 2'b00) begin
            errors++; $display("FAIL store_single_pulse got=%b%b want=00", bus.d_resp, bus.mem_write);
        end
        cyc();
    endtask

    task automatic test_tie();
        logic [31:0] first_a, second_a;
        do_reset();
`ifdef MEM_ARB_RR_EN
        first_a = 32'h400; second_a = 32'h300;  // last_grant=I after reset -> D, then I
`else
        first_a = 32'h400; second_a = 32'h400;  // D keeps winning
`endif
        bus.i_read = 1; bus.i_addr = 32'h300;
        bus.d_read = 1; bus.d_addr = 32'h400;
        cyc(); #1; checks++;
        if (bus.mem_addr !== first_a || bus.mem_read !== 1'b1) begin
            errors++; $display("FAIL tie_first got=%h rd=%b want=%h", bus.mem_addr, bus.mem_read, first_a);
        end
        bus.mem_resp = 1;
        cyc(); bus.mem_resp = 0;
        cyc(); #1; checks++;
        if (bus.mem_addr !== second_a || bus.mem_read !== 1'b1) begin
            errors++; $display("FAIL tie_second got=%h rd=%b want=%h", bus.mem_addr, bus.mem_read, second_a);
        end
        bus.mem_resp = 1;
        cyc(); clear_inputs();
        cyc();
    endtask

    task automatic test_back_to_back();
        bus.d_read = 1; bus.d_addr = 32'h500;             // cycle 1
        cyc(); bus.i_read = 1; bus.i_addr = 32'h600;       // cycle 2: D granted, I queued
        #1; checks++;
        if ({bus.mem_read, bus.mem_addr} !== {1'b1, 32'h500}) begin
            errors++; $display("FAIL b2b_d_grant got=%b %h want=1 500", bus.mem_read, bus.mem_addr);
        end
        cyc(); cyc(); cyc(); bus.mem_resp = 1;              // cycle 5
        #1; checks++;
        if ({bus.d_resp, bus.i_resp} !== 2'b10) begin
            errors++; $display("FAIL b2b_d_resp got=%b%b want=10", bus.d_resp, bus.i_resp);
        end
        cyc(); bus.mem_resp = 0; bus.d_read = 0;            // cycle 6: IDLE
        #1; checks++;
        if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b want=0", bus.mem_read); end
        cyc(); #1; checks++;                                // cycle 7
        if ({bus.mem_read, bus.mem_addr} !== {1'b1, 32'h600}) begin
            errors++; $display("FAIL b2b_i_grant got=%b %h want=1 600", bus.mem_read, bus.mem_addr);
        end
        bus.mem_resp = 1;
        cyc(); clear_inputs();
        cyc();
    endtask

    task automatic test_abort();
        bus.i_read = 1; bus.i_addr = 32'h700;
        cyc(); #1; checks++;
        if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL abort_grant got=%b want=1", bus.mem_read); end
        bus.i_read = 0;
        #1; checks++;
        if ({bus.mem_read, bus.i_resp} !== 2'b00) begin
            errors++; $display("FAIL abort_drop got=%b%b want=00", bus.mem_read, bus.i_resp);
        end
        cyc(); bus.mem_resp = 1;                             // stray response in IDLE
        #1; checks++;
        if ({bus.i_resp, bus.d_resp, bus.mem_read} !== 3'b000) begin
            errors++; $display("FAIL abort_stray got=%b%b%b want=000", bus.i_resp, bus.d_resp, bus.mem_read);
        end
        cyc(); bus.mem_resp = 0; bus.i_read = 1; bus.i_addr = 32'h704;
        cyc(); #1; checks++;
        if ({bus.mem_read, bus.mem_addr} !== {1'b1, 32'h704}) begin
            errors++; $display("FAIL abort_regrant got=%b %h want=1 704", bus.mem_read, bus.mem_addr);
        end
        bus.mem_resp = 1;
        cyc(); clear_inputs();
        cyc();
    endtask

    task automatic test_reset_mid();
        bus.d_write = 1; bus.d_addr = 32'h800; bus.d_wdata = 32'hA5A5A5A5; bus.d_wmask = 4'hF;
        cyc(); #1; checks++;
        if (bus.mem_write !== 1'b1) begin errors++; $display("FAIL rstmid_grant got=%b want=1", bus.mem_write); end
        rst = 1;
        cyc(); #1; checks++;
        if (outs() !== 84'd0) begin errors++; $display("FAIL rstmid_outputs got=%h want=0", outs()); end
        rst = 0; clear_inputs();
        cyc();
    endtask

    // Random traffic against a transaction-level owner model: the port is
    // owned by nobody, I or D; a finished or abandoned owner frees the port
    // and ownership is re-decided one cycle later from the held requests.
    task automatic test_random();
        int owner = 0;           // 0 none, 1 fetch, 2 load/store
        int last  = 1;           // last requester that won the port
        bit i_act = 0, d_act = 0, i_done = 0, d_done = 0;
        logic        e_rd, e_wr, e_ir, e_dr;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_mask;
        bit ireq, dreq, tie_d;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            // requester behaviour
            if (i_act && (i_done || $urandom_range(0, 19) == 0)) i_act = ($urandom_range(0, 1) == 0) && i_done;
            else if (!i_act && $urandom_range(0, 2) == 0) i_act = 1;
            if (i_act && (i_done || !bus.i_read)) bus.i_addr = $urandom;
            bus.i_read = i_act;
            if (d_act && (d_done || $urandom_range(0, 19) == 0)) d_act = ($urandom_range(0, 1) == 0) && d_done;
            else if (!d_act && $urandom_range(0, 2) == 0) d_act = 1;
            if (d_act && (d_done || !(bus.d_read | bus.d_write))) begin
                bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_wmask = 4'($urandom);
                case ($urandom_range(0, 2))
                    0: begin bus.d_read = 1; bus.d_write = 0; end
                    1: begin bus.d_read = 0; bus.d_write = 1; end
                    default: begin bus.d_read = 1; bus.d_write = 1; end
                endcase
            end
            if (!d_act) begin bus.d_read = 0; bus.d_write = 0; end
            bus.mem_resp  = ($urandom_range(0, 2) == 0);
            bus.mem_rdata = $urandom;
            #1;
            ireq = bus.i_read; dreq = bus.d_read | bus.d_write;
            e_rd = 0; e_wr = 0; e_addr = 0; e_wdata = 0; e_mask = 0; e_ir = 0; e_dr = 0;
            if (owner == 1 && ireq) begin
                e_rd = 1; e_addr = bus.i_addr; e_mask = 4'hF; e_ir = bus.mem_resp;
            end else if (owner == 2 && dreq) begin
                e_wr = bus.d_write; e_rd = !bus.d_write; e_addr = bus.d_addr;
                e_wdata = bus.d_wdata; e_mask = bus.d_write ? bus.d_wmask : 4'hF; e_dr = bus.mem_resp;
            end
            checks++;
            if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wmask} !== {e_rd, e_wr, e_addr, e_mask}) begin
                errors++; $display("FAIL rand_port c=%0d got=%b%b %h %h want=%b%b %h %h", c,
                    bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wmask, e_rd, e_wr, e_addr, e_mask);
            end
            if (e_wr) begin
                checks++;
                if (bus.mem_wdata !== e_wdata) begin
                    errors++; $display("FAIL rand_wdata c=%0d got=%h want=%h", c, bus.mem_wdata, e_wdata);
                end
            end
            checks++;
            if ({bus.i_resp, bus.d_resp} !== {e_ir, e_dr}) begin
                errors++; $display("FAIL rand_resp c=%0d got=%b%b want=%b%b", c, bus.i_resp, bus.d_resp, e_ir, e_dr);
            end
            checks++;
            if (bus.i_rdata !== bus.mem_rdata || bus.d_rdata !== bus.mem_rdata) begin
                errors++; $display("FAIL rand_rdata c=%0d got=%h/%h want=%h", c, bus.i_rdata, bus.d_rdata, bus.mem_rdata);
            end
            i_done = e_ir; d_done = e_dr;
            // ownership for next cycle
            if (owner == 1) owner = (!ireq || bus.mem_resp) ? 0 : 1;
            else if (owner == 2) owner = (!dreq || bus.mem_resp) ? 0 : 2;
            else if (ireq || dreq) begin
`ifdef MEM_ARB_RR_EN
                tie_d = (last == 1);
`else
                tie_d = 1;
`endif
                owner = (dreq && (!ireq || tie_d)) ? 2 : 1;
                last  = owner;
            end
            cyc();
        end
        clear_inputs();
        cyc();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_fetch();
        test_store_wait();
        test_tie();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
